zacore_decode: RTL and testbench

//  Decode stage of the Zacore RV32I pipeline, directly downstream of fetch. Accepts one fetched

---
 rtl/zacore_decode.sv | 268 ++++++++++++++++++++++++++
 tb/tb_zacore_decode.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zacore_decode.sv
// zacore_decode: RV32I decode stage sitting directly behind fetch.
// Decodes the presented instruction combinationally and holds the result in a
// single decode->execute register that uses a valid/ready handshake.
// Drives the stall back to fetch on execute backpressure or on a load-use
// interlock. A flush (invalidate) drops both the held and the presented instruction.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_fd_valid/pc/inst  instruction presented by fetch
//   o_stall             fetch must hold its PC and IMEM output
//   i_invalidate        pipeline flush
//   o_rf_rs1/rs2_addr   raw source fields of i_fd_inst, to the register file
//   i_ex_ready          execute accepts the held instruction
//   o_de_*              held, decoded instruction for execute
module zacore_decode #(
    parameter bit LOAD_USE_INTERLOCK = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fd_valid,
    input  logic [31:0] i_fd_pc,
    input  logic [31:0] i_fd_inst,
    output logic        o_stall,
    input  logic        i_invalidate,
    output logic [4:0]  o_rf_rs1_addr,
    output logic [4:0]  o_rf_rs2_addr,
    input  logic        i_ex_ready,
    output logic        o_de_valid,
    output logic [31:0] o_de_pc,
    output logic [4:0]  o_de_rs1,
    output logic [4:0]  o_de_rs2,
    output logic [4:0]  o_de_rd,
    output logic        o_de_rd_we,
    output logic [31:0] o_de_imm,
    output logic [3:0]  o_de_alu_op,
    output logic [2:0]  o_de_funct3,
    output logic        o_de_is_load,
    output logic        o_de_is_store,
    output logic        o_de_is_branch,
    output logic        o_de_is_jump,
    output logic        o_de_is_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = i_fd_inst[6:0];
    assign funct3 = i_fd_inst[14:12];
    assign funct7 = i_fd_inst[31:25];

    assign imm_i = {{20{i_fd_inst[31]}}, i_fd_inst[31:20]};
    assign imm_s = {{20{i_fd_inst[31]}}, i_fd_inst[31:25], i_fd_inst[11:7]};
    assign imm_b = {{19{i_fd_inst[31]}}, i_fd_inst[31], i_fd_inst[7],
                    i_fd_inst[30:25], i_fd_inst[11:8], 1'b0};
    assign imm_u = {i_fd_inst[31:12], 12'b0};
    assign imm_j = {{11{i_fd_inst[31]}}, i_fd_inst[31], i_fd_inst[19:12],
                    i_fd_inst[20], i_fd_inst[30:21], 1'b0};

    assign o_rf_rs1_addr = i_fd_inst[19:15];
    assign o_rf_rs2_addr = i_fd_inst[24:20];

    logic        use_rs1, use_rs2, wr_rd;
    logic        d_load, d_store, d_branch, d_jump, d_illegal;
    logic [31:0] d_imm;
    logic [3:0]  d_alu_op;
    logic [3:0]  base_op;
    logic [4:0]  d_rs1, d_rs2;
    logic        d_rd_we;

    // funct3 -> ALU op for the shared OP / OP-IMM encoding (funct7 picks SUB/SRA)
    always_comb begin
        base_op = ALU_ADD;
        case (funct3)
            3'b000: base_op = ALU_ADD;
            3'b001: base_op = ALU_SLL;
            3'b010: base_op = ALU_SLT;
            3'b011: base_op = ALU_SLTU;
            3'b100: base_op = ALU_XOR;
            3'b101: base_op = ALU_SRL;
            3'b110: base_op = ALU_OR;
            3'b111: base_op = ALU_AND;
            default: base_op = ALU_ADD;
        endcase
    end

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        wr_rd     = 1'b0;
        d_load    = 1'b0;
        d_store   = 1'b0;
        d_branch  = 1'b0;
        d_jump    = 1'b0;
        d_illegal = 1'b0;
        d_imm     = 32'd0;
        d_alu_op  = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                wr_rd    = 1'b1;
                d_imm    = imm_u;
                d_alu_op = ALU_PASSB;
            end
            OPC_AUIPC: begin
                wr_rd = 1'b1;
                d_imm = imm_u;
            end
            OPC_JAL: begin
                wr_rd  = 1'b1;
                d_imm  = imm_j;
                d_jump = 1'b1;
            end
            OPC_JALR: begin
                d_illegal = (funct3 != 3'b000);
                use_rs1   = 1'b1;
                wr_rd     = 1'b1;
                d_imm     = imm_i;
                d_jump    = 1'b1;
            end
            OPC_BRANCH: begin
                d_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                d_imm     = imm_b;
                d_branch  = 1'b1;
                // EQ/NE compare via SUB, signed/unsigned ordering via SLT/SLTU
                if (!funct3[2])     d_alu_op = ALU_SUB;
                else if (funct3[1]) d_alu_op = ALU_SLTU;
                else                d_alu_op = ALU_SLT;
            end
            OPC_LOAD: begin
                d_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                use_rs1   = 1'b1;
                wr_rd     = 1'b1;
                d_imm     = imm_i;
                d_load    = 1'b1;
            end
            OPC_STORE: begin
                d_illegal = funct3[2] || (funct3 == 3'b011);
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                d_imm     = imm_s;
                d_store   = 1'b1;
            end
            OPC_OPIMM: begin
                use_rs1  = 1'b1;
                wr_rd    = 1'b1;
                d_imm    = imm_i;
                d_alu_op = base_op;
                if (funct3 == 3'b001) begin
                    d_illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000)      d_alu_op  = ALU_SRA;
                    else if (funct7 != 7'b0000000) d_illegal = 1'b1;
                end
            end
            OPC_OP: begin
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                wr_rd    = 1'b1;
                d_alu_op = base_op;
                if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      d_alu_op  = ALU_SUB;
                    else if (funct3 == 3'b101) d_alu_op  = ALU_SRA;
                    else                       d_illegal = 1'b1;
                end else if (funct7 != 7'b0000000) begin
                    d_illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                d_illegal = (funct3 != 3'b000);
            end
            default: d_illegal = 1'b1;
        endcase

        // An illegal instruction travels on as a bare marker: nothing used, nothing written.
        if (d_illegal) begin
            use_rs1  = 1'b0;
            use_rs2  = 1'b0;
            wr_rd    = 1'b0;
            d_load   = 1'b0;
            d_store  = 1'b0;
            d_branch = 1'b0;
            d_jump   = 1'b0;
            d_imm    = 32'd0;
            d_alu_op = ALU_ADD;
        end
    end

    assign d_rs1   = use_rs1 ? i_fd_inst[19:15] : 5'd0;
    assign d_rs2   = use_rs2 ? i_fd_inst[24:20] : 5'd0;
    assign d_rd_we = wr_rd && (i_fd_inst[11:7] != 5'd0);

    logic ex_busy, hazard;

    assign ex_busy = o_de_valid && !i_ex_ready;
    // Unused source fields are already zeroed and o_de_rd is non-zero here,
    // so a plain equality also covers the "source is used" qualifier.
    assign hazard  = LOAD_USE_INTERLOCK && i_fd_valid && o_de_valid && o_de_is_load
                     && (o_de_rd != 5'd0)
                     && ((d_rs1 == o_de_rd) || (d_rs2 == o_de_rd));
    assign o_stall = !i_invalidate && (ex_busy || hazard);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_de_valid      <= 1'b0;
            o_de_pc         <= 32'd0;
            o_de_rs1        <= 5'd0;
            o_de_rs2        <= 5'd0;
            o_de_rd         <= 5'd0;
            o_de_rd_we      <= 1'b0;
            o_de_imm        <= 32'd0;
            o_de_alu_op     <= 4'd0;
            o_de_funct3     <= 3'd0;
            o_de_is_load    <= 1'b0;
            o_de_is_store   <= 1'b0;
            o_de_is_branch  <= 1'b0;
            o_de_is_jump    <= 1'b0;
            o_de_is_illegal <= 1'b0;
        end else if (i_invalidate) begin
            o_de_valid <= 1'b0;
        end else if (ex_busy) begin
            o_de_valid <= o_de_valid;
        end else if (hazard) begin
            o_de_valid <= 1'b0;
        end else begin
            o_de_valid      <= i_fd_valid;
            o_de_pc         <= i_fd_pc;
            o_de_rs1        <= d_rs1;
            o_de_rs2        <= d_rs2;
            o_de_rd         <= i_fd_inst[11:7];
            o_de_rd_we      <= d_rd_we;
            o_de_imm        <= d_imm;
            o_de_alu_op     <= d_alu_op;
            o_de_funct3     <= funct3;
            o_de_is_load    <= d_load;
            o_de_is_store   <= d_store;
            o_de_is_branch  <= d_branch;
            o_de_is_jump    <= d_jump;
            o_de_is_illegal <= d_illegal;
        end
    end

endmodule

// File: tb/tb_zacore_decode.sv
// Bench for zacore_decode: one instance with the load-use interlock and one without,
// both driven by the same stimulus and each checked every cycle against its own model.
module tb_zacore_decode;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        ld;
        logic        st;
        logic        br;
        logic        jp;
        logic        il;
    } de_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fd_valid = 1'b0;
    logic [31:0] fd_pc = 32'd0;
    logic [31:0] fd_inst = 32'd0;
    logic        invalidate = 1'b0;
    logic        ex_ready = 1'b0;

    logic        stall_w[2];
    logic [4:0]  rf1_w[2];
    logic [4:0]  rf2_w[2];
    logic        val_w[2];
    logic [31:0] pc_w[2];
    logic [4:0]  rs1_w[2];
    logic [4:0]  rs2_w[2];
    logic [4:0]  rd_w[2];
    logic        rdwe_w[2];
    logic [31:0] imm_w[2];
    logic [3:0]  alu_w[2];
    logic [2:0]  f3_w[2];
    logic        ld_w[2];
    logic        st_w[2];
    logic        br_w[2];
    logic        jp_w[2];
    logic        il_w[2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        zacore_decode #(.LOAD_USE_INTERLOCK(g == 0)) u_dut (
            .i_clk(clk), .i_rst(rst),
            .i_fd_valid(fd_valid), .i_fd_pc(fd_pc), .i_fd_inst(fd_inst),
            .o_stall(stall_w[g]), .i_invalidate(invalidate),
            .o_rf_rs1_addr(rf1_w[g]), .o_rf_rs2_addr(rf2_w[g]),
            .i_ex_ready(ex_ready),
            .o_de_valid(val_w[g]), .o_de_pc(pc_w[g]),
            .o_de_rs1(rs1_w[g]), .o_de_rs2(rs2_w[g]), .o_de_rd(rd_w[g]),
            .o_de_rd_we(rdwe_w[g]), .o_de_imm(imm_w[g]), .o_de_alu_op(alu_w[g]),
            .o_de_funct3(f3_w[g]),
            .o_de_is_load(ld_w[g]), .o_de_is_store(st_w[g]), .o_de_is_branch(br_w[g]),
            .o_de_is_jump(jp_w[g]), .o_de_is_illegal(il_w[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference decoder, written from the ISA tables.
    function automatic de_t ref_decode(input logic [31:0] pc, input logic [31:0] w);
        de_t r;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ok, u1, u2, wr;
        logic [3:0] base;
        r = '0;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        r.pc = pc;
        r.f3 = f3;
        r.rd = w[11:7];
        ok = 1'b1; u1 = 1'b0; u2 = 1'b0; wr = 1'b0;
        case (f3)
            3'd0: base = 4'd0;  3'd1: base = 4'd2;  3'd2: base = 4'd3;  3'd3: base = 4'd4;
            3'd4: base = 4'd5;  3'd5: base = 4'd6;  3'd6: base = 4'd8;  default: base = 4'd9;
        endcase
        case (op)
            7'h37: begin wr = 1; r.imm = {w[31:12], 12'h000}; r.alu = 4'd10; end
            7'h17: begin wr = 1; r.imm = {w[31:12], 12'h000}; end
            7'h6F: begin
                wr = 1; r.jp = 1;
                r.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            end
            7'h67: begin ok = (f3 == 0); u1 = 1; wr = 1; r.jp = 1; r.imm = 32'($signed(w[31:20])); end
            7'h63: begin
                ok = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
                u1 = 1; u2 = 1; r.br = 1;
                r.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                r.alu = (f3 < 4) ? 4'd1 : ((f3 >= 6) ? 4'd4 : 4'd3);
            end
            7'h03: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                u1 = 1; wr = 1; r.ld = 1; r.imm = 32'($signed(w[31:20]));
            end
            7'h23: begin
                ok = (f3 < 3); u1 = 1; u2 = 1; r.st = 1;
                r.imm = 32'($signed({w[31:25], w[11:7]}));
            end
            7'h13: begin
                u1 = 1; wr = 1; r.imm = 32'($signed(w[31:20])); r.alu = base;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    ok = (f7 == 0) || (f7 == 7'h20);
                    if (f7 == 7'h20) r.alu = 4'd7;
                end
            end
            7'h33: begin
                u1 = 1; wr = 1; u2 = 1;
                if (f7 == 0) r.alu = base;
                else if (f7 == 7'h20 && f3 == 0) r.alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 5) r.alu = 4'd7;
                else ok = 0;
            end
            7'h0F: ok = (f3 == 0);
            default: ok = 0;
        endcase
        if (!ok) begin
            r.imm = 0; r.alu = 0; r.ld = 0; r.st = 0; r.br = 0; r.jp = 0; r.il = 1;
        end else begin
            r.rs1 = u1 ? w[19:15] : 5'd0;
            r.rs2 = u2 ? w[24:20] : 5'd0;
            r.rd_we = wr && (w[11:7] != 0);
        end
        return r;
    endfunction

    function automatic logic model_hazard(input de_t s, input bit ilk, input logic fv, input logic [31:0] inst);
        de_t d;
        d = ref_decode(32'd0, inst);
        return ilk && fv && s.valid && s.ld && s.rd != 0 && (d.rs1 == s.rd || d.rs2 == s.rd);
    endfunction

    function automatic logic model_stall(input de_t s, input bit ilk, input logic fv,
                                         input logic [31:0] inst, input logic rdy, input logic inv);
        return !inv && ((s.valid && !rdy) || model_hazard(s, ilk, fv, inst));
    endfunction

    function automatic de_t model_next(input de_t s, input bit ilk, input logic fv, input logic [31:0] pc,
                                       input logic [31:0] inst, input logic rdy, input logic inv);
        de_t d;
        if (inv) begin
            s.valid = 0;
        end else if (s.valid && !rdy) begin
            return s;
        end else if (model_hazard(s, ilk, fv, inst)) begin
            s.valid = 0;
        end else begin
            d = ref_decode(pc, inst);
            d.valid = fv;
            return d;
        end
        return s;
    endfunction

    de_t m[2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m[0] = '0;
            m[1] = '0;
        end else begin
            for (int k = 0; k < 2; k++)
                m[k] = model_next(m[k], (k == 0), fd_valid, fd_pc, fd_inst, ex_ready, invalidate);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d.valid", k), {31'd0, val_w[k]}, {31'd0, m[k].valid});
            chk($sformatf("d%0d.stall", k), {31'd0, stall_w[k]},
                {31'd0, model_stall(m[k], (k == 0), fd_valid, fd_inst, ex_ready, invalidate)});
            chk($sformatf("d%0d.rf_rs1", k), {27'd0, rf1_w[k]}, {27'd0, fd_inst[19:15]});
            chk($sformatf("d%0d.rf_rs2", k), {27'd0, rf2_w[k]}, {27'd0, fd_inst[24:20]});
            chk($sformatf("d%0d.no_x", k),
                {31'd0, $isunknown({val_w[k], pc_w[k], rs1_w[k], rs2_w[k], rd_w[k], rdwe_w[k],
                                    imm_w[k], alu_w[k], f3_w[k], ld_w[k], st_w[k], br_w[k],
                                    jp_w[k], il_w[k], stall_w[k]})}, 32'd0);
            if (m[k].valid) begin
                chk($sformatf("d%0d.pc", k), pc_w[k], m[k].pc);
                chk($sformatf("d%0d.rs1", k), {27'd0, rs1_w[k]}, {27'd0, m[k].rs1});
                chk($sformatf("d%0d.rs2", k), {27'd0, rs2_w[k]}, {27'd0, m[k].rs2});
                chk($sformatf("d%0d.rd", k), {27'd0, rd_w[k]}, {27'd0, m[k].rd});
                chk($sformatf("d%0d.rd_we", k), {31'd0, rdwe_w[k]}, {31'd0, m[k].rd_we});
                chk($sformatf("d%0d.imm", k), imm_w[k], m[k].imm);
                chk($sformatf("d%0d.alu", k), {28'd0, alu_w[k]}, {28'd0, m[k].alu});
                chk($sformatf("d%0d.f3", k), {29'd0, f3_w[k]}, {29'd0, m[k].f3});
                chk($sformatf("d%0d.flags", k), {27'd0, ld_w[k], st_w[k], br_w[k], jp_w[k], il_w[k]},
                    {27'd0, m[k].ld, m[k].st, m[k].br, m[k].jp, m[k].il});
            end
        end
    end

    // Present inputs just after a rising edge, return at the following falling edge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic inv);
        @(posedge clk);
        #1;
        fd_valid = v; fd_pc = pc; fd_inst = inst; ex_ready = rdy; invalidate = inv;
        @(negedge clk);
    endtask

    logic [31:0] vec[14];
    de_t rd_tmp;

    initial begin
        vec[0] = 32'h407302B3;  vec[1] = 32'h40A4D433;  vec[2] = 32'h00309093;
        vec[3] = 32'h40309093;  vec[4] = 32'h0020A423;  vec[5] = 32'hFE208EE3;
        vec[6] = 32'h010000EF;  vec[7] = 32'h000100E7;  vec[8] = 32'h00001397;
        vec[9] = 32'h0000000F;  vec[10] = 32'h00002063; vec[11] = 32'hFFF24183;
        vec[12] = 32'h00022483; vec[13] = 32'h0092A023;

        // Hand-computed immediates pin the reference decoder.
        rd_tmp = ref_decode(0, 32'h0020A423);
        chk("ref.sw_imm", rd_tmp.imm, 32'd8);
        rd_tmp = ref_decode(0, 32'hFE208EE3);
        chk("ref.beq_imm", rd_tmp.imm, 32'hFFFFFFFC);
        rd_tmp = ref_decode(0, 32'h010000EF);
        chk("ref.jal_imm", rd_tmp.imm, 32'd16);

        repeat (2) @(negedge clk);
        chk("reset.valid", {31'd0, val_w[0]}, 32'd0);
        chk("reset.stall", {31'd0, stall_w[0]}, 32'd0);
        chk("reset.imm", imm_w[0], 32'd0);
        #2 rst = 1'b1;

        // ADDI x1,x0,5
        cyc(1, 32'h100, 32'h00500093, 1, 0);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("addi.valid", {31'd0, val_w[0]}, 32'd1);
        chk("addi.rd", {27'd0, rd_w[0]}, 32'd1);
        chk("addi.imm", imm_w[0], 32'd5);
        chk("addi.alu", {28'd0, alu_w[0]}, 32'd0);
        chk("addi.rd_we", {31'd0, rdwe_w[0]}, 32'd1);

        // LW x2,0(x1) then ADD x3,x2,x1: one bubble with interlock, none without
        cyc(1, 32'h104, 32'h0000A103, 1, 0);
        cyc(1, 32'h108, 32'h001101B3, 1, 0);
        chk("lu.stall", {31'd0, stall_w[0]}, 32'd1);
        chk("lu.nointerlock_stall", {31'd0, stall_w[1]}, 32'd0);
        cyc(1, 32'h108, 32'h001101B3, 1, 0);
        chk("lu.bubble", {31'd0, val_w[0]}, 32'd0);
        chk("lu.stall_once", {31'd0, stall_w[0]}, 32'd0);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("lu.add_valid", {31'd0, val_w[0]}, 32'd1);
        chk("lu.add_rs1", {27'd0, rs1_w[0]}, 32'd2);
        chk("lu.add_rs2", {27'd0, rs2_w[0]}, 32'd1);

        // Execute backpressure for 3 cycles
        cyc(1, 32'h10C, 32'h00A00213, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h110, 32'h00124333, 0, 0);
            chk("bp.stall", {31'd0, stall_w[0]}, 32'd1);
            chk("bp.pc_hold", pc_w[0], 32'h10C);
            chk("bp.imm_hold", imm_w[0], 32'd10);
        end
        cyc(1, 32'h110, 32'h00124333, 1, 0);
        chk("bp.release_stall", {31'd0, stall_w[0]}, 32'd0);

        // Invalidate while stalled
        cyc(1, 32'h114, 32'h00100393, 0, 0);
        chk("inv.pre_stall", {31'd0, stall_w[0]}, 32'd1);
        chk("inv.held_pc", pc_w[0], 32'h110);
        cyc(1, 32'h114, 32'h00100393, 0, 1);
        chk("inv.stall", {31'd0, stall_w[0]}, 32'd0);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("inv.valid", {31'd0, val_w[0]}, 32'd0);

        // LUI, then all-zero illegal word
        cyc(1, 32'h200, 32'h123452B7, 1, 0);
        cyc(1, 32'h204, 32'h00000000, 1, 0);
        chk("lui.imm", imm_w[0], 32'h12345000);
        chk("lui.alu", {28'd0, alu_w[0]}, 32'd10);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("ill.valid", {31'd0, val_w[0]}, 32'd1);
        chk("ill.flag", {31'd0, il_w[0]}, 32'd1);
        chk("ill.rd_we", {31'd0, rdwe_w[0]}, 32'd0);

        // LW x0 then ADD reading x0: no interlock
        cyc(1, 32'h300, 32'h00002003, 1, 0);
        cyc(1, 32'h304, 32'h000001B3, 1, 0);
        chk("x0.stall", {31'd0, stall_w[0]}, 32'd0);

        // Mixed vectors; fetch holds while the interlocked instance stalls.
        begin
            int i = 0;
            int guard = 0;
            while (i < 14 && guard < 200) begin
                cyc(1, 32'h400 + 32'(4 * i), vec[i], (guard % 4) != 3, guard == 9);
                if (!stall_w[0]) i++;
                guard++;
            end
            chk("vec.progress", i, 14);
        end

        // Asynchronous reset while an instruction is held
        cyc(1, 32'h500, 32'h00500093, 1, 0);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("areset.pre_valid", {31'd0, val_w[0]}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("areset.valid0", {31'd0, val_w[0]}, 32'd0);
        chk("areset.valid1", {31'd0, val_w[1]}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        cyc(0, 32'h0, 32'h0, 1, 0);
        cyc(0, 32'h0, 32'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
